// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid stage: occupancy encoding and
// default payload / drop-counter widths.
package pipe_pkg;

    localparam int PAYLOAD_W_DEF = 165;
    localparam int CNT_W_DEF     = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Number of live entries represented by an occupancy state.
    function automatic logic [1:0] occ_entries(input occ_e occ);
        logic [1:0] n;
        case (occ)
            OCC_EMPTY: n = 2'd0;
            OCC_ONE:   n = 2'd1;
            OCC_FULL:  n = 2'd2;
            default:   n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter advanced by 0..2 per cycle, with a synchronous clear
// that outranks any increment.
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic [1:0]       i_inc,
    output logic [CNT_W-1:0] o_count
);

    localparam int SUM_W = CNT_W + 2;

    logic [CNT_W-1:0] r_count;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_max;

    // Widened sum so the saturation test never sees a wrapped value.
    always_comb begin
        w_sum = SUM_W'(r_count) + SUM_W'(i_inc);
        w_max = SUM_W'({CNT_W{1'b1}});
    end

    // Count register: clear, saturate at all-ones, or take the sum.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (w_sum > w_max) begin
            r_count <= {CNT_W{1'b1}};
        end else begin
            r_count <= w_sum[CNT_W-1:0];
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_skid_stage.sv
// One pipeline register stage with optional skid entry, flush/hold/bubble
// controls and a saturating count of entries discarded by flush.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int SKID_EN   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 hold_i,
    input  logic                 bubble_i,
    input  logic                 valid_i,
    input  logic [PAYLOAD_W-1:0] data_i,
    output logic                 ready_o,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] data_o,
    input  logic                 ready_i,
    output logic [CNT_W-1:0]     drop_cnt_o
);

    occ_e                 r_state;
    logic [PAYLOAD_W-1:0] r_main;
    logic [PAYLOAD_W-1:0] w_skid;
    logic                 w_accept;
    logic                 w_consume;
    logic                 w_push_skid;
    logic                 w_pop_skid;
    logic [1:0]           w_drop_inc;

    // Upstream ready; without a skid entry a held item must leave this cycle.
    always_comb begin
        if (hold_i || bubble_i || flush_i) begin
            ready_o = 1'b0;
        end else if (SKID_EN != 0) begin
            ready_o = (r_state != OCC_FULL);
        end else begin
            ready_o = (r_state == OCC_EMPTY) || ready_i;
        end
    end

    assign valid_o = (r_state != OCC_EMPTY);
    assign data_o  = r_main;

    // Handshake decode shared by the occupancy FSM and the skid register.
    always_comb begin
        w_accept    = valid_i & ready_o;
        w_consume   = valid_o & ready_i & ~hold_i & ~flush_i;
        w_push_skid = (r_state == OCC_ONE) & w_accept & ~w_consume;
        w_pop_skid  = (r_state == OCC_FULL) & w_consume;
        if (flush_i) begin
            w_drop_inc = occ_entries(r_state);
        end else begin
            w_drop_inc = 2'd0;
        end
    end

    // Occupancy FSM and main register; main is zeroed whenever it empties.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            r_state <= OCC_EMPTY;
            r_main  <= '0;
        end else if (hold_i) begin
            r_state <= r_state;
            r_main  <= r_main;
        end else begin
            case (r_state)
                OCC_EMPTY: begin
                    if (w_accept) begin
                        r_state <= OCC_ONE;
                        r_main  <= data_i;
                    end
                end
                OCC_ONE: begin
                    if (w_accept && w_consume) begin
                        r_main <= data_i;
                    end else if (w_push_skid && (SKID_EN != 0)) begin
                        r_state <= OCC_FULL;
                    end else if (w_consume) begin
                        r_state <= OCC_EMPTY;
                        r_main  <= '0;
                    end
                end
                OCC_FULL: begin
                    if (w_consume) begin
                        r_state <= OCC_ONE;
                        r_main  <= w_skid;
                    end
                end
                default: begin
                    r_state <= OCC_EMPTY;
                    r_main  <= '0;
                end
            endcase
        end
    end

    if (SKID_EN != 0) begin : g_skid
        logic [PAYLOAD_W-1:0] r_skid;

        // Skid entry catches the item accepted while downstream is stalled.
        always_ff @(posedge clk) begin
            if (reset || flush_i) begin
                r_skid <= '0;
            end else if (w_push_skid) begin
                r_skid <= data_i;
            end else if (w_pop_skid) begin
                r_skid <= '0;
            end else begin
                r_skid <= r_skid;
            end
        end

        assign w_skid = r_skid;
    end else begin : g_no_skid
        assign w_skid = '0;
    end

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_drop_cnt (
        .clk     (clk),
        .i_clear (reset),
        .i_inc   (w_drop_inc),
        .o_count (drop_cnt_o)
    );

endmodule
